// File: rtl/writeback_regfile.sv
// Write-back stage and architectural register file for the Y86-64 pipeline.
// - Commits W_valE / W_valM into 15 writable 64-bit registers. reg15 is
//   hard-wired to zero.
// - Tracks sticky program status and counts retired (non-bubble) instructions.
// - There is no internal bypass. The decode stage forwards W_* values itself.
module writeback_regfile #(
  parameter int                 DATA_W    = 64,
  parameter logic [DATA_W-1:0]  RESET_RSP = 'h200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        W_stat,
  input  logic [3:0]        W_icode,
  input  logic [3:0]        W_dstE,
  input  logic [3:0]        W_dstM,
  input  logic [DATA_W-1:0] W_valE,
  input  logic [DATA_W-1:0] W_valM,
  input  logic              W_stall,
  output logic [DATA_W-1:0] reg0,
  output logic [DATA_W-1:0] reg1,
  output logic [DATA_W-1:0] reg2,
  output logic [DATA_W-1:0] reg3,
  output logic [DATA_W-1:0] reg4,
  output logic [DATA_W-1:0] reg5,
  output logic [DATA_W-1:0] reg6,
  output logic [DATA_W-1:0] reg7,
  output logic [DATA_W-1:0] reg8,
  output logic [DATA_W-1:0] reg9,
  output logic [DATA_W-1:0] reg10,
  output logic [DATA_W-1:0] reg11,
  output logic [DATA_W-1:0] reg12,
  output logic [DATA_W-1:0] reg13,
  output logic [DATA_W-1:0] reg14,
  output logic [DATA_W-1:0] reg15,
  output logic [1:0]        prog_stat,
  output logic              halted,
  output logic [63:0]       retired_count
);

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [3:0] ICODE_NOP = 4'h1;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t             r_state;
  logic [1:0]         r_prog_stat;
  logic               r_halted;
  logic [63:0]        r_retired;

  logic               w_commit;
  logic               w_retire;
  logic [DATA_W-1:0]  w_regs [16];

  // A commit needs a running machine, no stall and an AOK instruction in W.
  // Non-AOK instructions write nothing and are not counted.
  assign w_commit = (r_state == ST_RUN) && !W_stall && (W_stat == STAT_AOK);
  assign w_retire = w_commit && (W_icode != ICODE_NOP);

  // Registers 0..14 are real storage.
  // When dstE and dstM name the same register, valM takes priority.
  // This gives popq %rsp its architectural behaviour.
  for (genvar gi = 0; gi < 15; gi++) begin : g_reg
    localparam logic [3:0]        IDX = 4'(gi);
    localparam logic [DATA_W-1:0] RST = (gi == 4) ? RESET_RSP : '0;

    logic [DATA_W-1:0] r_q;

    // Load valM or valE into this register on a committing edge.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= RST;
      end else if (w_commit && (W_dstM == IDX)) begin
        r_q <= W_valM;
      end else if (w_commit && (W_dstE == IDX)) begin
        r_q <= W_valE;
      end
    end

    assign w_regs[gi] = r_q;
  end

  // Index F means "no destination", so register 15 never holds a value.
  assign w_regs[15] = '0;

  // Status FSM.
  // - The first unstalled non-AOK instruction moves the machine to HALT.
  // - HALT is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_prog_stat <= STAT_AOK;
      r_halted    <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (!W_stall && (W_stat != STAT_AOK)) begin
            r_state     <= ST_HALT;
            r_prog_stat <= W_stat;
            r_halted    <= 1'b1;
          end
        end
        ST_HALT: begin
          r_state     <= ST_HALT;
          r_prog_stat <= r_prog_stat;
          r_halted    <= 1'b1;
        end
        default: begin
          r_state     <= ST_RUN;
          r_prog_stat <= STAT_AOK;
          r_halted    <= 1'b0;
        end
      endcase
    end
  end

  // Count committed non-bubble instructions. The count wraps naturally at 2^64.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + 64'd1;
    end
  end

  // Only dstE/dstM equal to F means "none".
  // The comparison is kept explicit here so the encoding is documented in one place.
  logic w_unused_none;
  assign w_unused_none = (W_dstE == REG_NONE) & (W_dstM == REG_NONE);

  assign reg0  = w_regs[0];
  assign reg1  = w_regs[1];
  assign reg2  = w_regs[2];
  assign reg3  = w_regs[3];
  assign reg4  = w_regs[4];
  assign reg5  = w_regs[5];
  assign reg6  = w_regs[6];
  assign reg7  = w_regs[7];
  assign reg8  = w_regs[8];
  assign reg9  = w_regs[9];
  assign reg10 = w_regs[10];
  assign reg11 = w_regs[11];
  assign reg12 = w_regs[12];
  assign reg13 = w_regs[13];
  assign reg14 = w_regs[14];
  assign reg15 = w_regs[15];

  assign prog_stat     = r_prog_stat;
  assign halted        = r_halted;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile.
// - Table-driven directed vectors.
// - Hand-written reset, halt and stall sequences.
// - Randomized traffic checked against an architectural model.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  W_stat;
  logic [3:0]  W_icode;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic        W_stall;
  logic [63:0] r [16];
  logic [1:0]  prog_stat;
  logic        halted;
  logic [63:0] retired_count;

  int n_pass = 0;
  int n_total = 0;

  // Architectural model
  logic [63:0] m_regs [16];
  logic        m_halt;
  logic [1:0]  m_stat;
  logic [63:0] m_cnt;

  always #5 clk = ~clk;

  writeback_regfile #(.DATA_W(64), .RESET_RSP(64'h200)) dut (
    .clk(clk), .rst_n(rst_n),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM), .W_stall(W_stall),
    .reg0(r[0]), .reg1(r[1]), .reg2(r[2]), .reg3(r[3]),
    .reg4(r[4]), .reg5(r[5]), .reg6(r[6]), .reg7(r[7]),
    .reg8(r[8]), .reg9(r[9]), .reg10(r[10]), .reg11(r[11]),
    .reg12(r[12]), .reg13(r[13]), .reg14(r[14]), .reg15(r[15]),
    .prog_stat(prog_stat), .halted(halted), .retired_count(retired_count)
  );

  typedef struct {
    logic        stall;
    logic [1:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [63:0] valE;
    logic [63:0] valM;
    int          chk_idx;
    logic [63:0] exp_val;
    logic [63:0] exp_cnt;
    logic        exp_halt;
    logic [1:0]  exp_pstat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 64'd0;
    m_regs[4] = 64'h200;
    m_halt = 1'b0;
    m_stat = 2'd0;
    m_cnt = 64'd0;
  endtask

  // One rising edge as the specification describes it.
  task automatic model_edge();
    if (!m_halt && !W_stall) begin
      if (W_stat != 2'd0) begin
        m_halt = 1'b1;
        m_stat = W_stat;
      end else begin
        if (W_dstE != 4'hF) m_regs[W_dstE] = W_valE;
        if (W_dstM != 4'hF) m_regs[W_dstM] = W_valM;
        if (W_icode != 4'h1) m_cnt = m_cnt + 64'd1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 16; i++) chk($sformatf("%s reg%0d", tag, i), r[i], m_regs[i]);
    chk({tag, " halted"}, {63'd0, halted}, {63'd0, m_halt});
    chk({tag, " prog_stat"}, {62'd0, prog_stat}, {62'd0, m_stat});
    chk({tag, " retired_count"}, retired_count, m_cnt);
  endtask

  task automatic drive(input logic stall, input logic [1:0] stat, input logic [3:0] icode,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [63:0] ve, input logic [63:0] vm);
    W_stall = stall; W_stat = stat; W_icode = icode;
    W_dstE = de; W_dstM = dm; W_valE = ve; W_valM = vm;
  endtask

  // Present inputs, take one edge, update the model, then sample 1 time unit later.
  task automatic step(input string tag, input logic stall, input logic [1:0] stat,
                      input logic [3:0] icode, input logic [3:0] de, input logic [3:0] dm,
                      input logic [63:0] ve, input logic [63:0] vm);
    drive(stall, stat, icode, de, dm, ve, vm);
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  // Apply async reset away from any clock edge and check it acts immediately.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{1'b0, 2'd0, 4'h6, 4'h3, 4'hF, 64'd5, 64'd0, 3, 64'd5, 64'd1, 1'b0, 2'd0};
    vecs[1] = '{1'b0, 2'd0, 4'hB, 4'h4, 4'h7, 64'h208, 64'd9, 7, 64'd9, 64'd2, 1'b0, 2'd0};
    vecs[2] = '{1'b0, 2'd0, 4'hB, 4'h4, 4'h4, 64'h208, 64'h1234, 4, 64'h1234, 64'd3, 1'b0, 2'd0};
    vecs[3] = '{1'b1, 2'd0, 4'h6, 4'h2, 4'hF, 64'd7, 64'd0, 2, 64'd0, 64'd3, 1'b0, 2'd0};
    vecs[4] = '{1'b0, 2'd0, 4'h1, 4'hF, 4'hF, 64'd7, 64'd7, 15, 64'd0, 64'd3, 1'b0, 2'd0};
    vecs[5] = '{1'b0, 2'd3, 4'h6, 4'h2, 4'hF, 64'd7, 64'd0, 2, 64'd0, 64'd3, 1'b1, 2'd3};

    drive(1'b0, 2'd0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    rst_n = 1'b1;

    // Directed table: dual write, conflict, stall, bubble, INS exception
    for (int k = 0; k < 6; k++) begin
      step($sformatf("vec%0d", k), vecs[k].stall, vecs[k].stat, vecs[k].icode,
           vecs[k].dstE, vecs[k].dstM, vecs[k].valE, vecs[k].valM);
      chk($sformatf("vec%0d reg%0d", k, vecs[k].chk_idx), r[vecs[k].chk_idx], vecs[k].exp_val);
      chk($sformatf("vec%0d count", k), retired_count, vecs[k].exp_cnt);
      chk($sformatf("vec%0d halted", k), {63'd0, halted}, {63'd0, vecs[k].exp_halt});
      chk($sformatf("vec%0d prog_stat", k), {62'd0, prog_stat}, {62'd0, vecs[k].exp_pstat});
    end

    // HALT freezes everything, even an AOK instruction that would write
    step("frozen", 1'b0, 2'd0, 4'h6, 4'h2, 4'h5, 64'd7, 64'd11);
    chk("frozen reg2", r[2], 64'd0);
    chk("frozen halted", {63'd0, halted}, 64'd1);

    // Reset mid-run takes effect without a clock edge
    async_reset("rst_from_halt");
    step("after_rst_commit", 1'b0, 2'd0, 4'h6, 4'h2, 4'hF, 64'd7, 64'd0);
    chk("after_rst reg2", r[2], 64'd7);
    chk("after_rst count", retired_count, 64'd1);

    // HLT instruction itself: halt, no write, no count
    step("hlt", 1'b0, 2'd1, 4'h0, 4'h2, 4'hF, 64'd99, 64'd0);
    chk("hlt prog_stat", {62'd0, prog_stat}, 64'd1);
    chk("hlt reg2", r[2], 64'd7);
    chk("hlt count", retired_count, 64'd1);
    async_reset("rst_hlt");

    // ADR under stall is ignored until the stall drops
    step("adr_stalled", 1'b1, 2'd2, 4'h5, 4'h3, 4'hF, 64'd1, 64'd0);
    chk("adr_stalled halted", {63'd0, halted}, 64'd0);
    step("adr_go", 1'b0, 2'd2, 4'h5, 4'h3, 4'hF, 64'd1, 64'd0);
    chk("adr_go halted", {63'd0, halted}, 64'd1);
    chk("adr_go prog_stat", {62'd0, prog_stat}, 64'd2);
    chk("adr_go reg3", r[3], 64'd0);
    async_reset("rst_adr");

    // Randomized traffic against the model
    for (int it = 0; it < 600; it++) begin
      logic        s;
      logic [1:0]  st;
      s  = ($urandom % 5) == 0;
      st = (($urandom % 40) == 0) ? 2'(1 + ($urandom % 3)) : 2'd0;
      step($sformatf("rand%0d", it), s, st, 4'($urandom % 12), 4'($urandom % 16),
           4'($urandom % 16), {$urandom, $urandom}, {$urandom, $urandom});
      if (m_halt && (($urandom % 6) == 0)) async_reset($sformatf("rand_rst%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
